// File: rtl/ifu_fetch_axi_ctrl.sv
// IFU fetch-side AXI4 read master: prefetches burst-aligned INCR bursts into a
// first-word fall-through line buffer and restarts at a new PC on flush.
module ifu_fetch_axi_ctrl #(
    parameter int          DataW     = 64,
    parameter int          FifoDepth = 16,
    parameter int          BurstLen  = 4,
    parameter int          IdW       = 4,
    parameter logic [31:0] ResetVec  = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_en,
    input  logic             flush,
    input  logic [30:0]      flush_pc,
    output logic [IdW-1:0]   axi_arid_f,
    output logic [31:0]      axi_araddr_f,
    output logic [7:0]       axi_arlen_f,
    output logic [2:0]       axi_arsize_f,
    output logic [1:0]       axi_arburst_f,
    output logic             axi_arlock_f,
    output logic [3:0]       axi_arcache_f,
    output logic [2:0]       axi_arprot_f,
    output logic [3:0]       axi_arqos_f,
    output logic [3:0]       axi_arregion_f,
    output logic             axi_arvalid_f,
    input  logic             axi_arready_f,
    input  logic [IdW-1:0]   axi_rid_f,
    input  logic [DataW-1:0] axi_rdata_f,
    input  logic [1:0]       axi_rresp_f,
    input  logic             axi_rlast_f,
    input  logic             axi_rvalid_f,
    output logic             axi_rready_f,
    output logic             wl_valid,
    input  logic             wl_ready,
    output logic [DataW-1:0] wl_data,
    output logic [31:0]      wl_addr,
    output logic             wl_err,
    output logic             busy
);
    localparam int          BeatB     = DataW / 8;
    localparam int          BurstB    = BeatB * BurstLen;
    localparam int          PtrW      = $clog2(FifoDepth);
    localparam int          CntW      = PtrW + 1;
    localparam int          EntW      = DataW + 33;
    localparam logic [31:0] BurstMask = ~(32'(BurstB) - 32'd1);
    localparam logic [31:0] BurstInc  = 32'(BurstB);
    localparam logic [31:0] BeatInc   = 32'(BeatB);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e          state_r, state_nx_s;
    logic [31:0]     fetch_addr_r, ar_addr_r, beat_addr_r;
    logic            flush_seen_r;
    logic [EntW-1:0] mem_r [FifoDepth];
    logic [PtrW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CntW-1:0] count_r;
    logic [EntW-1:0] head_s;
    logic            push_s, pop_s, issue_s, data_last_s;
    logic            unused_rid_s;

    assign unused_rid_s = ^axi_rid_f;

    // Next-state decode: one burst outstanding, buffer space reserved before issue.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fetch_en && !flush && (count_r <= CntW'(FifoDepth - BurstLen))) state_nx_s = ST_ADDR;
                else state_nx_s = ST_IDLE;
            end
            ST_ADDR: begin
                if (axi_arready_f) begin
                    if (flush || flush_seen_r) state_nx_s = ST_DRAIN;
                    else state_nx_s = ST_DATA;
                end else begin
                    state_nx_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (axi_rvalid_f && axi_rlast_f) state_nx_s = ST_IDLE;
                else if (flush) state_nx_s = ST_DRAIN;
                else state_nx_s = ST_DATA;
            end
            ST_DRAIN: begin
                if (axi_rvalid_f && axi_rlast_f) state_nx_s = ST_IDLE;
                else state_nx_s = ST_DRAIN;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    assign issue_s     = (state_r == ST_IDLE) && (state_nx_s == ST_ADDR);
    assign data_last_s = (state_r == ST_DATA) && axi_rvalid_f && axi_rlast_f;
    assign push_s      = (state_r == ST_DATA) && axi_rvalid_f && !flush;
    assign pop_s       = wl_ready && (count_r != {CntW{1'b0}}) && !flush;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nx_s;
    end

    // Fetch, AR and beat address tracking; a flush redirects fetch but araddr stays held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_addr_r <= ResetVec;
            ar_addr_r    <= 32'h0000_0000;
            beat_addr_r  <= 32'h0000_0000;
            flush_seen_r <= 1'b0;
        end else begin
            if (flush) fetch_addr_r <= {flush_pc, 1'b0} & BurstMask;
            else if (data_last_s) fetch_addr_r <= fetch_addr_r + BurstInc;
            else fetch_addr_r <= fetch_addr_r;

            if (issue_s) begin
                ar_addr_r   <= fetch_addr_r & BurstMask;
                beat_addr_r <= fetch_addr_r & BurstMask;
            end else if (push_s) begin
                beat_addr_r <= beat_addr_r + BeatInc;
            end else begin
                beat_addr_r <= beat_addr_r;
            end

            if (state_r == ST_ADDR) flush_seen_r <= !axi_arready_f && (flush_seen_r || flush);
            else flush_seen_r <= 1'b0;
        end
    end

    // Buffer pointers and occupancy; flush empties the buffer and voids any push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PtrW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PtrW'(1);
            if (push_s && !pop_s) count_r <= count_r + CntW'(1);
            else if (!push_s && pop_s) count_r <= count_r - CntW'(1);
            else count_r <= count_r;
        end
    end

    // Buffer storage: {err, beat address, data}.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= {(axi_rresp_f != 2'b00), beat_addr_r, axi_rdata_f};
    end

    assign head_s   = mem_r[rd_ptr_r];
    assign wl_valid = (count_r != {CntW{1'b0}});
    assign wl_data  = head_s[DataW-1:0];
    assign wl_addr  = head_s[DataW+31:DataW];
    assign wl_err   = head_s[EntW-1];
    assign busy     = (state_r != ST_IDLE);

    assign axi_arid_f     = {IdW{1'b0}};
    assign axi_araddr_f   = ar_addr_r;
    assign axi_arlen_f    = 8'(BurstLen - 1);
    assign axi_arsize_f   = 3'($clog2(BeatB));
    assign axi_arburst_f  = 2'b01;
    assign axi_arlock_f   = 1'b0;
    assign axi_arcache_f  = 4'b0000;
    assign axi_arprot_f   = 3'b000;
    assign axi_arqos_f    = 4'b0000;
    assign axi_arregion_f = 4'b0000;
    assign axi_arvalid_f  = (state_r == ST_ADDR);
    assign axi_rready_f   = (state_r == ST_DATA) || (state_r == ST_DRAIN);
endmodule

// File: tb/tb_ifu_fetch_axi_ctrl.sv
// Bench for ifu_fetch_axi_ctrl: random AXI slave and consumer, checked every cycle
// against a transaction-level model of the expected AR stream and buffered beats.
module tb_ifu_fetch_axi_ctrl;
    localparam logic [31:0] RV = 32'hFFFF_FFE0;

    logic        clk, rst_n, fetch_en, flush, wl_ready;
    logic [30:0] flush_pc;
    logic [3:0]  axi_arid_f, axi_arcache_f, axi_arqos_f, axi_arregion_f, axi_rid_f;
    logic [31:0] axi_araddr_f, wl_addr;
    logic [7:0]  axi_arlen_f;
    logic [2:0]  axi_arsize_f, axi_arprot_f;
    logic [1:0]  axi_arburst_f, axi_rresp_f;
    logic        axi_arlock_f, axi_arvalid_f, axi_arready_f, axi_rlast_f, axi_rvalid_f, axi_rready_f;
    logic [63:0] axi_rdata_f, wl_data;
    logic        wl_valid, wl_err, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int ar_prob = 100;
    int r_prob  = 100;

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] addr;
        logic        err;
    } beat_t;

    beat_t       m_q[$];
    logic [31:0] m_fetch, m_ar_addr, m_baddr;
    bit          m_ar_pend, m_fl_in_ar, m_live;
    int          m_left;

    ifu_fetch_axi_ctrl #(.DataW(64), .FifoDepth(16), .BurstLen(4), .IdW(4), .ResetVec(RV)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .flush(flush), .flush_pc(flush_pc),
        .axi_arid_f(axi_arid_f), .axi_araddr_f(axi_araddr_f), .axi_arlen_f(axi_arlen_f),
        .axi_arsize_f(axi_arsize_f), .axi_arburst_f(axi_arburst_f), .axi_arlock_f(axi_arlock_f),
        .axi_arcache_f(axi_arcache_f), .axi_arprot_f(axi_arprot_f), .axi_arqos_f(axi_arqos_f),
        .axi_arregion_f(axi_arregion_f), .axi_arvalid_f(axi_arvalid_f), .axi_arready_f(axi_arready_f),
        .axi_rid_f(axi_rid_f), .axi_rdata_f(axi_rdata_f), .axi_rresp_f(axi_rresp_f),
        .axi_rlast_f(axi_rlast_f), .axi_rvalid_f(axi_rvalid_f), .axi_rready_f(axi_rready_f),
        .wl_valid(wl_valid), .wl_ready(wl_ready), .wl_data(wl_data), .wl_addr(wl_addr),
        .wl_err(wl_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] dfn(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ar(output logic [31:0] addr);
        bit found;
        found = 1'b0;
        addr  = 32'h0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (axi_arvalid_f && axi_arready_f) begin
                found = 1'b1;
                addr  = axi_araddr_f;
            end
        end
        chk("ar_handshake_timeout", 64'(found), 64'd1);
    endtask

    task automatic wait_wl(output logic [31:0] addr);
        bit found;
        found = 1'b0;
        addr  = 32'h0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (wl_valid && wl_ready) begin
                found = 1'b1;
                addr  = wl_addr;
            end
        end
        chk("wl_pop_timeout", 64'(found), 64'd1);
    endtask

    // AXI slave: decides at the falling edge, drives just after the rising edge.
    initial begin : slave
        int          sl_left, sl_idx, arp, rp;
        logic [31:0] sl_addr;
        bit          accepted;
        axi_arready_f = 1'b0; axi_rvalid_f = 1'b0; axi_rdata_f = 64'h0;
        axi_rresp_f = 2'b00; axi_rlast_f = 1'b0; axi_rid_f = 4'h0;
        sl_left = 0; sl_idx = 0; sl_addr = 32'h0;
        forever begin
            @(negedge clk);
            arp = ar_prob;
            rp  = r_prob;
            accepted = axi_rvalid_f && axi_rready_f;
            if (!rst_n) begin
                sl_left  = 0;
                accepted = 1'b1;
            end else begin
                if (accepted) begin sl_left--; sl_idx++; end
                if (axi_arvalid_f && axi_arready_f) begin
                    sl_addr = axi_araddr_f; sl_left = 4; sl_idx = 0;
                end
            end
            @(posedge clk);
            #1;
            axi_arready_f = ($urandom_range(99) < arp);
            if (axi_rvalid_f && !accepted) begin
                axi_rvalid_f = 1'b1;
            end else if (sl_left > 0 && $urandom_range(99) < rp) begin
                axi_rvalid_f = 1'b1;
                axi_rdata_f  = dfn(sl_addr + 32'(sl_idx * 8));
                axi_rresp_f  = ($urandom_range(7) == 0) ? 2'b10 : 2'b00;
                axi_rlast_f  = (sl_left == 1);
            end else begin
                axi_rvalid_f = 1'b0;
                axi_rlast_f  = 1'b0;
            end
        end
    end

    // Reference model: expected AR stream and buffer contents, compared every cycle.
    initial begin : model
        beat_t       b;
        int          size0;
        bit          idle0;
        logic [31:0] ftgt;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_q.delete(); m_ar_pend = 1'b0; m_fl_in_ar = 1'b0; m_live = 1'b0;
                m_left = 0; m_fetch = RV;
                chk("reset_arvalid", 64'(axi_arvalid_f), 64'd0);
                chk("reset_rready", 64'(axi_rready_f), 64'd0);
                chk("reset_wl_valid", 64'(wl_valid), 64'd0);
                chk("reset_busy", 64'(busy), 64'd0);
            end else begin
                idle0 = !m_ar_pend && (m_left == 0);
                size0 = m_q.size();
                ftgt  = {flush_pc, 1'b0} & 32'hFFFF_FFE0;
                chk("arvalid", 64'(axi_arvalid_f), 64'(m_ar_pend));
                if (m_ar_pend) begin
                    chk("araddr", 64'(axi_araddr_f), 64'(m_ar_addr));
                    chk("arlen", 64'(axi_arlen_f), 64'd3);
                    chk("arsize", 64'(axi_arsize_f), 64'd3);
                    chk("arburst", 64'(axi_arburst_f), 64'd1);
                end
                chk("rready", 64'(axi_rready_f), 64'(m_left > 0));
                chk("busy", 64'(busy), 64'(!idle0));
                chk("wl_valid", 64'(wl_valid), 64'(size0 > 0));
                if (size0 > 0) begin
                    chk("wl_data", wl_data, m_q[0].data);
                    chk("wl_addr", 64'(wl_addr), 64'(m_q[0].addr));
                    chk("wl_err", 64'(wl_err), 64'(m_q[0].err));
                    if (wl_ready && !flush) void'(m_q.pop_front());
                end
                if ((m_left > 0) && axi_rvalid_f) begin
                    if (m_live && !flush) begin
                        b.data = dfn(m_baddr);
                        b.addr = m_baddr;
                        b.err  = (axi_rresp_f != 2'b00);
                        m_q.push_back(b);
                        if (m_left == 1) m_fetch = m_fetch + 32'h20;
                    end
                    m_baddr = m_baddr + 32'd8;
                    m_left--;
                end
                if (m_ar_pend) begin
                    if (flush) m_fl_in_ar = 1'b1;
                    if (axi_arready_f) begin
                        m_ar_pend = 1'b0; m_left = 4; m_live = !m_fl_in_ar;
                        m_baddr = m_ar_addr; m_fl_in_ar = 1'b0;
                    end
                end else if (idle0 && fetch_en && !flush && size0 <= 12) begin
                    m_ar_pend = 1'b1;
                    m_ar_addr = m_fetch & 32'hFFFF_FFE0;
                end
                if (flush) begin
                    m_q.delete(); m_live = 1'b0; m_fetch = ftgt;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] a;
        bit          ok;
        int          hs;
        rst_n = 1'b0; fetch_en = 1'b0; flush = 1'b0; flush_pc = 31'h0; wl_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; fetch_en = 1'b1;

        // Reset vector near the top of memory: bursts wrap to zero.
        wait_ar(a); chk("first_araddr", 64'(a), 64'hFFFF_FFE0);
        for (int i = 0; i < 4; i++) begin
            wait_wl(a); chk("first_burst_wl_addr", 64'(a), 64'(32'hFFFF_FFE0 + 32'(i * 8)));
        end
        wait_ar(a); chk("wrapped_araddr", 64'(a), 64'h0);
        wait_wl(a); chk("wrap_burst_beat0", 64'(a), 64'h0);

        // Redirect mid-burst to 0x8000_1006.
        @(posedge clk); #1 flush = 1'b1; flush_pc = 31'h4000_0803;
        @(posedge clk); #1 flush = 1'b0;
        wait_ar(a); chk("redirect_araddr", 64'(a), 64'h8000_1000);
        wait_wl(a); chk("redirect_first_wl_addr", 64'(a), 64'h8000_1000);

        // Redirect while AR is stalled by the slave.
        @(posedge clk); #1 ar_prob = 0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = axi_arvalid_f; end
        chk("arvalid_while_stalled", 64'(ok), 64'd1);
        chk("stalled_araddr", 64'(axi_araddr_f), 64'h8000_1020);
        @(posedge clk); #1 flush = 1'b1; flush_pc = 31'h4800_0020;
        @(posedge clk); #1 flush = 1'b0;
        repeat (4) @(posedge clk);
        #1 ar_prob = 100;
        wait_ar(a); chk("stalled_ar_held", 64'(a), 64'h8000_1020);
        wait_ar(a); chk("post_drain_araddr", 64'(a), 64'h9000_0040);
        wait_wl(a); chk("post_drain_wl_addr", 64'(a), 64'h9000_0040);

        // Back-pressure: buffer fills with exactly four bursts.
        @(posedge clk); #1 fetch_en = 1'b0; ar_prob = 70; r_prob = 70;
        repeat (60) @(posedge clk);
        #1 wl_ready = 1'b0; flush = 1'b1; flush_pc = 31'h4000_0000; fetch_en = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        hs = 0;
        repeat (200) begin @(negedge clk); if (axi_arvalid_f && axi_arready_f) hs++; end
        chk("bursts_without_pops", 64'(hs), 64'd4);
        chk("buffer_full_wl_valid", 64'(wl_valid), 64'd1);
        @(posedge clk); #1 wl_ready = 1'b1;
        @(posedge clk); #1 wl_ready = 1'b0;
        hs = 0;
        repeat (30) begin @(negedge clk); if (axi_arvalid_f && axi_arready_f) hs++; end
        chk("no_ar_after_one_pop", 64'(hs), 64'd0);
        @(posedge clk); #1 wl_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 wl_ready = 1'b0;
        hs = 0;
        repeat (60) begin @(negedge clk); if (axi_arvalid_f && axi_arready_f) hs++; end
        chk("ar_after_four_pops", 64'(hs), 64'd1);

        // Randomized traffic with random flushes, stalls and consumer back-pressure.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (c % 200 == 0) begin
                ar_prob = int'($urandom_range(100, 20));
                r_prob  = int'($urandom_range(100, 30));
            end
            wl_ready = ($urandom_range(3) != 0);
            fetch_en = ($urandom_range(9) != 0);
            flush    = ($urandom_range(39) == 0);
            if ($urandom_range(3) == 0) flush_pc = 31'({24'hFFFF_FF, 8'($urandom)} >> 1);
            else flush_pc = 31'({16'h8000, 16'($urandom)} >> 1);
        end

        // Reset asserted mid-traffic returns everything to reset values.
        @(posedge clk); #1 flush = 1'b0; fetch_en = 1'b1; wl_ready = 1'b1; ar_prob = 100; r_prob = 100;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ar(a); chk("araddr_after_reset", 64'(a), 64'hFFFF_FFE0);
        wait_wl(a); chk("wl_addr_after_reset", 64'(a), 64'hFFFF_FFE0);
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
